// File: rtl/pmod_gpio_bank_if.sv
// Register-access bus between the shim (master) and the GPIO bank (slave).
// Read data is registered in the slave and qualified by reg_rvalid.
interface pmod_gpio_bank_if #(
    parameter int N_PINS = 8
);
    logic [2:0]        reg_addr;
    logic              reg_wr;
    logic [N_PINS-1:0] reg_wdata;
    logic              reg_rd;
    logic [N_PINS-1:0] reg_rdata;
    logic              reg_rvalid;

    modport master (
        output reg_addr, reg_wr, reg_wdata, reg_rd,
        input  reg_rdata, reg_rvalid
    );

    modport slave (
        input  reg_addr, reg_wr, reg_wdata, reg_rd,
        output reg_rdata, reg_rvalid
    );
endinterface

// File: rtl/pmod_gpio_bank.sv
// PMOD/GPIO pin bank: per-pin output/tri-state registers, synchronised and
// debounced inputs, and sticky W1C edge interrupts.
module pmod_gpio_bank #(
    parameter int N_PINS          = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_PINS-1:0]    pin_i,
    output logic [N_PINS-1:0]    pin_o,
    output logic [N_PINS-1:0]    pin_t,
    pmod_gpio_bank_if.slave      bus,
    output logic                 irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] ADDR_DATA_OUT   = 3'd0;
    localparam logic [2:0] ADDR_TRI        = 3'd1;
    localparam logic [2:0] ADDR_DATA_IN    = 3'd2;
    localparam logic [2:0] ADDR_RISE_EN    = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN    = 3'd4;
    localparam logic [2:0] ADDR_IRQ_EN     = 3'd5;
    localparam logic [2:0] ADDR_IRQ_STATUS = 3'd6;

    logic [N_PINS-1:0] data_out;
    logic [N_PINS-1:0] tri_ctl;
    logic [N_PINS-1:0] rise_en;
    logic [N_PINS-1:0] fall_en;
    logic [N_PINS-1:0] irq_en;
    logic [N_PINS-1:0] irq_status;

    logic [N_PINS-1:0] sync1;
    logic [N_PINS-1:0] sync2;
    logic [N_PINS-1:0] stable;
    logic [N_PINS-1:0] stable_d;
    logic [CW-1:0]     cnt [N_PINS];

    logic [N_PINS-1:0] rise;
    logic [N_PINS-1:0] fall;
    logic [N_PINS-1:0] edge_set;
    logic [N_PINS-1:0] w1c_mask;
    logic [N_PINS-1:0] rd_mux;

    always_comb begin
        rise     = stable & ~stable_d;
        fall     = ~stable & stable_d;
        edge_set = (rise & rise_en) | (fall & fall_en);
        w1c_mask = '0;
        if (bus.reg_wr && bus.reg_addr == ADDR_IRQ_STATUS) begin
            w1c_mask = bus.reg_wdata;
        end
    end

    // Read mux sees pre-edge register values, so a same-cycle write is not visible.
    always_comb begin
        rd_mux = '0;
        case (bus.reg_addr)
            ADDR_DATA_OUT:   rd_mux = data_out;
            ADDR_TRI:        rd_mux = tri_ctl;
            ADDR_DATA_IN:    rd_mux = stable;
            ADDR_RISE_EN:    rd_mux = rise_en;
            ADDR_FALL_EN:    rd_mux = fall_en;
            ADDR_IRQ_EN:     rd_mux = irq_en;
            ADDR_IRQ_STATUS: rd_mux = irq_status;
            default:         rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
            tri_ctl  <= '1;
            rise_en  <= '0;
            fall_en  <= '0;
            irq_en   <= '0;
        end else if (bus.reg_wr) begin
            case (bus.reg_addr)
                ADDR_DATA_OUT: data_out <= bus.reg_wdata;
                ADDR_TRI:      tri_ctl  <= bus.reg_wdata;
                ADDR_RISE_EN:  rise_en  <= bus.reg_wdata;
                ADDR_FALL_EN:  fall_en  <= bus.reg_wdata;
                ADDR_IRQ_EN:   irq_en   <= bus.reg_wdata;
                default: ;
            endcase
        end
    end

    // Set has priority over a simultaneous write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_status <= '0;
        end else begin
            irq_status <= (irq_status & ~w1c_mask) | edge_set;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.reg_rdata  <= '0;
            bus.reg_rvalid <= 1'b0;
        end else begin
            bus.reg_rvalid <= bus.reg_rd;
            if (bus.reg_rd) begin
                bus.reg_rdata <= rd_mux;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < N_PINS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= pin_i;
            sync2    <= sync1;
            stable_d <= stable;
            // Counter tops out at DEBOUNCE_CYCLES-1, so it cannot wrap.
            for (int i = 0; i < N_PINS; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        stable[i] <= sync2[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign pin_o = data_out;
    assign pin_t = tri_ctl;
    assign irq   = |(irq_status & irq_en);

endmodule

// File: tb/tb_pmod_gpio_bank.sv
// Directed bench for pmod_gpio_bank: reads go through a scoreboard queue
// checked by a separate monitor; pin and irq levels are checked inline.
module tb_pmod_gpio_bank;
    localparam int N  = 8;
    localparam int DB = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] pin_i;
    logic [N-1:0] pin_o;
    logic [N-1:0] pin_t;
    logic         irq;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pmod_gpio_bank_if #(.N_PINS(N)) bus ();

    pmod_gpio_bank #(.N_PINS(N), .DEBOUNCE_CYCLES(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .pin_i (pin_i),
        .pin_o (pin_o),
        .pin_t (pin_t),
        .bus   (bus),
        .irq   (irq)
    );

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        bus.reg_wr    = 1'b1;
        tick();
        bus.reg_wr    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp);
        bus.reg_addr = a;
        bus.reg_rd   = 1'b1;
        sb.push_back('{addr: a, data: exp, cyc: cyc + 1});
        tick();
        bus.reg_rd   = 1'b0;
    endtask

    task automatic rdwr(input logic [2:0] a, input logic [7:0] d, input logic [7:0] exp);
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        bus.reg_rd    = 1'b1;
        bus.reg_wr    = 1'b1;
        sb.push_back('{addr: a, data: exp, cyc: cyc + 1});
        tick();
        bus.reg_rd    = 1'b0;
        bus.reg_wr    = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.reg_rvalid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL read unexpected rvalid data=%h t=%0t", bus.reg_rdata, $time);
            end else begin
                e = sb.pop_front();
                if (bus.reg_rdata !== e.data || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL read addr=%0d got=%h cyc=%0d want=%h cyc=%0d",
                             e.addr, bus.reg_rdata, cyc, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        pin_i         = '0;
        bus.reg_addr  = '0;
        bus.reg_wdata = '0;
        bus.reg_wr    = 1'b0;
        bus.reg_rd    = 1'b0;
        tick();
        reset = 1'b0;

        // reset state
        chk("rst pin_t", pin_t, 8'hFF);
        chk("rst pin_o", pin_o, 8'h00);
        chk("rst irq", 8'(irq), 8'h00);
        chk("rst rvalid", 8'(bus.reg_rvalid), 8'h00);
        rd(3'd1, 8'hFF);
        rd(3'd7, 8'h00);

        // output path, read-during-write, ignored writes
        wr(3'd1, 8'h0F);
        chk("pin_t", pin_t, 8'h0F);
        wr(3'd0, 8'hA5);
        chk("pin_o", pin_o, 8'hA5);
        rd(3'd0, 8'hA5);
        rdwr(3'd0, 8'h3C, 8'hA5);
        chk("pin_o rdwr", pin_o, 8'h3C);
        rd(3'd0, 8'h3C);
        wr(3'd2, 8'hFF);
        wr(3'd7, 8'hFF);
        rd(3'd2, 8'h00);
        rd(3'd7, 8'h00);

        // debounce latency: stable after edge 18, first read to see it samples at edge 19
        pin_i[3] = 1'b1;
        for (int k = 1; k <= 20; k++) rd(3'd2, (k >= 19) ? 8'h08 : 8'h00);

        // 10-cycle glitch is rejected
        pin_i[4] = 1'b1;
        repeat (10) tick();
        pin_i[4] = 1'b0;
        for (int k = 1; k <= 25; k++) rd(3'd2, 8'h08);

        // rising-edge interrupt: status/irq one edge after DATA_IN changes
        wr(3'd3, 8'h01);
        wr(3'd5, 8'h01);
        pin_i[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("irq rise", 8'(irq), (k >= 19) ? 8'h01 : 8'h00);
        end
        rd(3'd6, 8'h01);
        rd(3'd2, 8'h09);

        // falling edge with FALL_EN=0 leaves status alone
        pin_i[0] = 1'b0;
        repeat (22) tick();
        rd(3'd2, 8'h08);
        rd(3'd6, 8'h01);
        chk("irq after fall", 8'(irq), 8'h01);

        wr(3'd6, 8'h01);
        chk("irq w1c", 8'(irq), 8'h00);
        rd(3'd6, 8'h00);

        // W1C racing a new set on the same edge: set wins
        pin_i[0] = 1'b1;
        repeat (18) tick();
        wr(3'd6, 8'h01);
        chk("irq race", 8'(irq), 8'h01);
        rd(3'd6, 8'h01);

        // IRQ_EN masks without clearing status
        wr(3'd5, 8'h00);
        chk("irq masked", 8'(irq), 8'h00);
        rd(3'd6, 8'h01);
        wr(3'd5, 8'h01);
        chk("irq unmasked", 8'(irq), 8'h01);
        wr(3'd6, 8'h01);
        chk("irq clear", 8'(irq), 8'h00);
        rd(3'd6, 8'h00);

        // reset mid-debounce (cnt=10 on pin 5); full latency restarts for all high pins
        pin_i[5] = 1'b1;
        repeat (12) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid rst pin_t", pin_t, 8'hFF);
        chk("mid rst pin_o", pin_o, 8'h00);
        chk("mid rst irq", 8'(irq), 8'h00);
        chk("mid rst rvalid", 8'(bus.reg_rvalid), 8'h00);
        for (int k = 1; k <= 20; k++) rd(3'd2, (k >= 19) ? 8'h29 : 8'h00);
        rd(3'd6, 8'h00);
        chk("irq end", 8'(irq), 8'h00);

        repeat (3) tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL pending reads got=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
